// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of fetched {instr, pc, pc+4} entries between fetch and decode; RESET async active-low, FLUSH clears all entries
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      FLUSH,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [DATA_W-1:0]         IN_INSTR,
  input  logic [DATA_W-1:0]         IN_PC,
  input  logic [DATA_W-1:0]         IN_PC_PLUS4,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [DATA_W-1:0]         OUT_INSTR,
  output logic [DATA_W-1:0]         OUT_PC,
  output logic [DATA_W-1:0]         OUT_PC_PLUS4,
  output logic [$clog2(DEPTH):0]    COUNT,
  output logic                      FULL,
  output logic                      EMPTY
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [3*DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop;
  logic [3*DATA_W-1:0] head;
  assign FULL      = count == CW'(DEPTH);
  assign EMPTY     = count == '0;
  assign COUNT     = count;
  assign OUT_VALID = !EMPTY;
  assign IN_READY  = !FULL || OUT_READY;
  assign push      = IN_VALID && IN_READY && !FLUSH;
  assign pop       = OUT_VALID && OUT_READY && !FLUSH;
  assign head      = mem[rd_ptr];
  assign OUT_INSTR    = OUT_VALID ? head[3*DATA_W-1:2*DATA_W] : '0;
  assign OUT_PC       = OUT_VALID ? head[2*DATA_W-1:DATA_W]   : '0;
  assign OUT_PC_PLUS4 = OUT_VALID ? head[DATA_W-1:0]          : '0;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {IN_INSTR, IN_PC, IN_PC_PLUS4};
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard-based self-checking bench for fetch_queue
module tb_fetch_queue;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] i;
    logic [31:0] p;
    logic [31:0] p4;
  } ent_t;
  logic CLK = 0, RESET = 0, FLUSH = 0, IN_VALID = 0, OUT_READY = 0;
  logic IN_READY, OUT_VALID, FULL, EMPTY;
  logic [31:0] IN_INSTR = 0, IN_PC = 0, IN_PC_PLUS4 = 0;
  logic [31:0] OUT_INSTR, OUT_PC, OUT_PC_PLUS4;
  logic [2:0] COUNT;
  ent_t q[$];
  int checks = 0, failures = 0;
  fetch_queue #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_INSTR(IN_INSTR), .IN_PC(IN_PC), .IN_PC_PLUS4(IN_PC_PLUS4),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_INSTR(OUT_INSTR), .OUT_PC(OUT_PC),
    .OUT_PC_PLUS4(OUT_PC_PLUS4), .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
  );
  always #5 CLK = ~CLK;
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    IN_VALID    = v;
    IN_PC       = pc;
    IN_INSTR    = instr;
    IN_PC_PLUS4 = pc + 32'd4;
  endtask
  // advances one clock and updates the model from the inputs that were presented
  task automatic tick();
    bit acc, pp;
    ent_t e;
    acc = IN_VALID && (q.size() < DEPTH || OUT_READY) && !FLUSH;
    pp  = q.size() > 0 && OUT_READY && !FLUSH;
    e.i = IN_INSTR; e.p = IN_PC; e.p4 = IN_PC_PLUS4;
    @(posedge CLK);
    if (FLUSH) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
  endtask
  task automatic test_reset();
    #2;
    checks++; if (COUNT !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
    checks++; if (EMPTY !== 1'b1 || FULL !== 1'b0) begin failures++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", EMPTY, FULL); end
    checks++; if (OUT_VALID !== 1'b0 || OUT_PC !== 32'd0 || OUT_INSTR !== 32'd0 || OUT_PC_PLUS4 !== 32'd0) begin failures++; $display("FAIL reset_out got v=%b pc=%h exp 0", OUT_VALID, OUT_PC); end
    @(posedge CLK); #1;
    RESET = 1;
    #1;
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", IN_READY); end
  endtask
  task automatic test_stall();
    logic [31:0] exp_pc[3] = '{32'h0, 32'h4, 32'h8};
    OUT_READY = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1, exp_pc[k], 32'hA000_0000 + k);
      tick();
      checks++; if (OUT_PC !== 32'h0) begin failures++; $display("FAIL stall_head got=%h exp=0", OUT_PC); end
    end
    drive(0, 0, 0);
    #1;
    checks++; if (COUNT !== 3'd3) begin failures++; $display("FAIL stall_count got=%0d exp=3", COUNT); end
    OUT_READY = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== exp_pc[k] || OUT_INSTR !== q[0].i || OUT_PC_PLUS4 !== exp_pc[k] + 4) begin failures++; $display("FAIL stall_drain%0d got pc=%h exp=%h", k, OUT_PC, exp_pc[k]); end
      tick();
    end
    checks++; if (EMPTY !== 1'b1 || OUT_VALID !== 1'b0) begin failures++; $display("FAIL stall_empty got empty=%b exp=1", EMPTY); end
    OUT_READY = 0;
  endtask
  task automatic test_full_and_wrap();
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'(4 * k), 32'hB000_0000 + k);
      tick();
    end
    drive(1, 32'h10, 32'hB000_0010);
    #1;
    checks++; if (FULL !== 1'b1 || IN_READY !== 1'b0) begin failures++; $display("FAIL full_flags got full=%b in_ready=%b exp 1/0", FULL, IN_READY); end
    tick();
    checks++; if (COUNT !== 3'd4 || OUT_PC !== 32'h0) begin failures++; $display("FAIL full_blocked got count=%0d pc=%h exp 4/0", COUNT, OUT_PC); end
    OUT_READY = 1;
    for (int k = 0; k < 6; k++) begin
      drive(1, 32'h10 + 32'(4 * k), 32'hC000_0000 + k);
      #1;
      checks++; if (IN_READY !== 1'b1 || OUT_PC !== 32'(4 * k) || OUT_INSTR !== q[0].i) begin failures++; $display("FAIL wrap_out%0d got pc=%h rdy=%b exp pc=%h", k, OUT_PC, IN_READY, 32'(4 * k)); end
      tick();
      checks++; if (COUNT !== 3'd4 || FULL !== 1'b1) begin failures++; $display("FAIL wrap_count%0d got=%0d exp=4", k, COUNT); end
    end
    drive(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (OUT_PC !== 32'h18 + 32'(4 * k) || OUT_PC_PLUS4 !== q[0].p4) begin failures++; $display("FAIL wrap_drain%0d got pc=%h exp=%h", k, OUT_PC, 32'h18 + 32'(4 * k)); end
      tick();
    end
    OUT_READY = 0;
  endtask
  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h20 + 32'(4 * k), 32'hD000_0000 + k);
      tick();
    end
    checks++; if (COUNT !== 3'd3) begin failures++; $display("FAIL flush_pre got=%0d exp=3", COUNT); end
    drive(1, 32'h40, 32'hD000_0040);
    FLUSH = 1;
    tick();
    FLUSH = 0;
    drive(0, 0, 0);
    #1;
    checks++; if (COUNT !== 3'd0 || OUT_VALID !== 1'b0 || OUT_PC !== 32'd0) begin failures++; $display("FAIL flush_clear got count=%0d v=%b pc=%h exp 0/0/0", COUNT, OUT_VALID, OUT_PC); end
    drive(1, 32'h80, 32'hD000_0080);
    tick();
    drive(0, 0, 0);
    #1;
    checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== 32'h80 || OUT_INSTR !== 32'hD000_0080 || COUNT !== 3'd1) begin failures++; $display("FAIL flush_next got pc=%h count=%0d exp 80/1", OUT_PC, COUNT); end
    OUT_READY = 1;
    tick();
    OUT_READY = 0;
  endtask
  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1, 32'h60 + 32'(4 * k), 32'hE000_0000 + k);
      tick();
    end
    drive(0, 0, 0);
    checks++; if (COUNT !== 3'd2) begin failures++; $display("FAIL areset_pre got=%0d exp=2", COUNT); end
    #1;
    RESET = 0;
    #1;
    q.delete();
    checks++; if (OUT_VALID !== 1'b0 || COUNT !== 3'd0 || EMPTY !== 1'b1) begin failures++; $display("FAIL areset_immediate got v=%b count=%0d exp 0/0", OUT_VALID, COUNT); end
    @(posedge CLK); #1;
    RESET = 1;
    drive(1, 32'h100, 32'hE000_0100);
    tick();
    drive(0, 0, 0);
    #1;
    checks++; if (OUT_PC !== 32'h100 || OUT_PC_PLUS4 !== 32'h104 || COUNT !== 3'd1) begin failures++; $display("FAIL areset_push got pc=%h count=%0d exp 100/1", OUT_PC, COUNT); end
    OUT_READY = 1;
    tick();
    OUT_READY = 0;
  endtask
  task automatic test_random();
    logic [31:0] pc = 32'h1000;
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 3) != 0, pc, $urandom);
      OUT_READY = $urandom_range(0, 2) != 0;
      FLUSH = $urandom_range(0, 40) == 0;
      #1;
      checks++; if (COUNT !== 3'(q.size()) || FULL !== (q.size() == DEPTH) || IN_READY !== (q.size() < DEPTH || OUT_READY)) begin failures++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, COUNT, q.size()); end
      if (q.size() > 0) begin
        checks++; if (OUT_VALID !== 1'b1 || OUT_INSTR !== q[0].i || OUT_PC !== q[0].p || OUT_PC_PLUS4 !== q[0].p4) begin failures++; $display("FAIL rand_head c=%0d got pc=%h instr=%h exp pc=%h instr=%h", c, OUT_PC, OUT_INSTR, q[0].p, q[0].i); end
      end else begin
        checks++; if (OUT_VALID !== 1'b0 || OUT_INSTR !== 32'd0 || OUT_PC !== 32'd0 || OUT_PC_PLUS4 !== 32'd0) begin failures++; $display("FAIL rand_empty c=%0d got v=%b pc=%h exp 0", c, OUT_VALID, OUT_PC); end
      end
      if (IN_VALID && IN_READY && !FLUSH) pc = pc + 32'd4;
      tick();
    end
    FLUSH = 0;
    OUT_READY = 0;
    drive(0, 0, 0);
  endtask
  initial begin
    test_reset();
    test_stall();
    test_full_and_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
